// File: rtl/datapath_pkg.sv
// datapath_pkg -- shared constants, bus-source encoding and helpers for the
// datapath block.
//   WORD_W     : register / bus width
//   PC_INC     : amount added by the IncPC ALU op
//   bus_sel_e  : bus sources; the enum value is the priority rank (0 wins)
//   pick_src   : priority encoder from the raw drive selects to bus_sel_e
//   sext19     : sign-extends an IR[18:0] constant to a full word
package datapath_pkg;

  localparam int WORD_W  = 32;
  localparam int NUM_SRC = 10;
  localparam logic [WORD_W-1:0] PC_INC = 32'd1;

  // Order matters: lower value = higher priority on the bus.
  typedef enum logic [3:0] {
    SEL_PC     = 4'd0,
    SEL_MDR    = 4'd1,
    SEL_ZLO    = 4'd2,
    SEL_ZHI    = 4'd3,
    SEL_HI     = 4'd4,
    SEL_LO     = 4'd5,
    SEL_R2     = 4'd6,
    SEL_R3     = 4'd7,
    SEL_C      = 4'd8,
    SEL_INPORT = 4'd9,
    SEL_NONE   = 4'd10
  } bus_sel_e;

  // req[i] is the drive select whose rank is i; lowest asserted index wins.
  function automatic bus_sel_e pick_src(input logic [NUM_SRC-1:0] req);
    bus_sel_e sel;
    sel = SEL_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) sel = bus_sel_e'(4'(i));
    end
    return sel;
  endfunction

  function automatic logic [WORD_W-1:0] sext19(input logic [18:0] v);
    return {{(WORD_W-19){v[18]}}, v};
  endfunction

endpackage

// File: rtl/datapath_reg32.sv
// reg32 -- one word register with synchronous active-low clear and load enable.
//   clk  : rising-edge clock
//   clr  : synchronous clear, active low, wins over i_ld
//   i_ld : load enable
//   i_d  : load data
//   o_q  : current contents
module reg32
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              i_ld,
  input  logic [WORD_W-1:0] i_d,
  output logic [WORD_W-1:0] o_q
);

  logic [WORD_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!clr)      r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/datapath.sv
// datapath -- single-bus CPU datapath: register file slice, MDR, HI/LO, Y,
// 64-bit Z and a small ALU, all connected through one priority-muxed bus.
//   clk, clr          : clock, synchronous active-low reset
//   MDatain, Read     : memory read data and MDR source select
//   *in strobes       : register load enables (R1..Zin)
//   *out selects      : bus drive selects, PCout highest priority
//   IncPC, AND        : ALU op selects (default op is add)
//   BusMuxOut, *q, Z* : observation of the bus and register contents
module datapath
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [WORD_W-1:0] MDatain,
  input  logic              Read,
  input  logic              R1in,
  input  logic              R2in,
  input  logic              R3in,
  input  logic              PCin,
  input  logic              IRin,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Yin,
  input  logic              Zin,
  input  logic              R2out,
  input  logic              R3out,
  input  logic              PCout,
  input  logic              MDRout,
  input  logic              Zlowout,
  input  logic              Zhighout,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              Cout,
  input  logic              InPortout,
  input  logic              IncPC,
  input  logic              AND,
  output logic [WORD_W-1:0] BusMuxOut,
  output logic [WORD_W-1:0] PCq,
  output logic [WORD_W-1:0] IRq,
  output logic [WORD_W-1:0] MARq,
  output logic [WORD_W-1:0] R1q,
  output logic [WORD_W-1:0] R2q,
  output logic [WORD_W-1:0] R3q,
  output logic [WORD_W-1:0] Zlo,
  output logic [WORD_W-1:0] Zhi
);

  // Registers that load straight from the bus share one instance array.
  localparam int NUM_BREG = 7;
  localparam int RI_R1  = 0;
  localparam int RI_R2  = 1;
  localparam int RI_R3  = 2;
  localparam int RI_PC  = 3;
  localparam int RI_IR  = 4;
  localparam int RI_MAR = 5;
  localparam int RI_Y   = 6;

  logic [NUM_BREG-1:0]             w_bld;
  logic [NUM_BREG-1:0][WORD_W-1:0] w_bq;
  logic [WORD_W-1:0]               w_bus;
  logic [WORD_W-1:0]               w_mdr_d;
  logic [WORD_W-1:0]               w_mdr_q;
  logic [WORD_W-1:0]               w_hi_q;
  logic [WORD_W-1:0]               w_lo_q;
  logic [WORD_W-1:0]               w_zlo_q;
  logic [WORD_W-1:0]               w_zhi_q;
  logic [WORD_W-1:0]               w_alu;
  logic [NUM_SRC-1:0]              w_req;
  bus_sel_e                        w_sel;

  assign w_bld = {Yin, MARin, IRin, PCin, R3in, R2in, R1in};

  for (genvar g = 0; g < NUM_BREG; g++) begin : g_breg
    reg32 u_reg (
      .clk  (clk),
      .clr  (clr),
      .i_ld (w_bld[g]),
      .i_d  (w_bus),
      .o_q  (w_bq[g])
    );
  end

  assign w_mdr_d = Read ? MDatain : w_bus;

  reg32 u_mdr (.clk(clk), .clr(clr), .i_ld(MDRin), .i_d(w_mdr_d), .o_q(w_mdr_q));

  // HI/LO have no writer in this block; they only ever hold the reset value.
  reg32 u_hi  (.clk(clk), .clr(clr), .i_ld(1'b0), .i_d('0), .o_q(w_hi_q));
  reg32 u_lo  (.clk(clk), .clr(clr), .i_ld(1'b0), .i_d('0), .o_q(w_lo_q));

  // Z is two words; every ALU op produces a zero upper half.
  reg32 u_zlo (.clk(clk), .clr(clr), .i_ld(Zin), .i_d(w_alu), .o_q(w_zlo_q));
  reg32 u_zhi (.clk(clk), .clr(clr), .i_ld(Zin), .i_d('0),    .o_q(w_zhi_q));

  // Bit position == priority rank in bus_sel_e.
  assign w_req = {InPortout, Cout, R3out, R2out, LOout, HIout,
                  Zhighout, Zlowout, MDRout, PCout};
  assign w_sel = pick_src(w_req);

  always_comb begin
    w_bus = '0;
    case (w_sel)
      SEL_PC:  w_bus = w_bq[RI_PC];
      SEL_MDR: w_bus = w_mdr_q;
      SEL_ZLO: w_bus = w_zlo_q;
      SEL_ZHI: w_bus = w_zhi_q;
      SEL_HI:  w_bus = w_hi_q;
      SEL_LO:  w_bus = w_lo_q;
      SEL_R2:  w_bus = w_bq[RI_R2];
      SEL_R3:  w_bus = w_bq[RI_R3];
      SEL_C:   w_bus = sext19(w_bq[RI_IR][18:0]);
      default: w_bus = '0;  // input port and no-select both read as zero
    endcase
  end

  always_comb begin
    w_alu = w_bq[RI_Y] + w_bus;
    if (IncPC)    w_alu = w_bus + PC_INC;
    else if (AND) w_alu = w_bq[RI_Y] & w_bus;
  end

  assign BusMuxOut = w_bus;
  assign PCq       = w_bq[RI_PC];
  assign IRq       = w_bq[RI_IR];
  assign MARq      = w_bq[RI_MAR];
  assign R1q       = w_bq[RI_R1];
  assign R2q       = w_bq[RI_R2];
  assign R3q       = w_bq[RI_R3];
  assign Zlo       = w_zlo_q;
  assign Zhi       = w_zhi_q;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath -- directed vector table plus hand sequences for reset.
module tb_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] mdat;
  logic [21:0] ctl;
  logic [31:0] bus, pcq, irq, marq, r1q, r2q, r3q, zlo, zhi;

  always #5 clk = ~clk;

  localparam logic [21:0] R1IN  = 22'd1 << 0,  R2IN   = 22'd1 << 1,  R3IN   = 22'd1 << 2;
  localparam logic [21:0] PCIN  = 22'd1 << 3,  IRIN   = 22'd1 << 4,  MARIN  = 22'd1 << 5;
  localparam logic [21:0] MDRIN = 22'd1 << 6,  YIN    = 22'd1 << 7,  ZIN    = 22'd1 << 8;
  localparam logic [21:0] R2OUT = 22'd1 << 9,  R3OUT  = 22'd1 << 10, PCOUT  = 22'd1 << 11;
  localparam logic [21:0] MDROUT= 22'd1 << 12, ZLOOUT = 22'd1 << 13, ZHIOUT = 22'd1 << 14;
  localparam logic [21:0] HIOUT = 22'd1 << 15, LOOUT  = 22'd1 << 16, COUT   = 22'd1 << 17;
  localparam logic [21:0] INOUT = 22'd1 << 18, INCPC  = 22'd1 << 19, ANDOP  = 22'd1 << 20;
  localparam logic [21:0] READ  = 22'd1 << 21;

  // Observation ids; O_NONE = step only, no comparison.
  localparam int O_BUS = 0, O_PC = 1, O_IR = 2, O_MAR = 3, O_R1 = 4;
  localparam int O_R2 = 5, O_R3 = 6, O_ZLO = 7, O_ZHI = 8, O_NONE = 9;

  datapath dut (
    .clk(clk), .clr(clr), .MDatain(mdat), .Read(ctl[21]),
    .R1in(ctl[0]), .R2in(ctl[1]), .R3in(ctl[2]), .PCin(ctl[3]), .IRin(ctl[4]),
    .MARin(ctl[5]), .MDRin(ctl[6]), .Yin(ctl[7]), .Zin(ctl[8]),
    .R2out(ctl[9]), .R3out(ctl[10]), .PCout(ctl[11]), .MDRout(ctl[12]),
    .Zlowout(ctl[13]), .Zhighout(ctl[14]), .HIout(ctl[15]), .LOout(ctl[16]),
    .Cout(ctl[17]), .InPortout(ctl[18]), .IncPC(ctl[19]), .AND(ctl[20]),
    .BusMuxOut(bus), .PCq(pcq), .IRq(irq), .MARq(marq),
    .R1q(r1q), .R2q(r2q), .R3q(r3q), .Zlo(zlo), .Zhi(zhi)
  );

  typedef struct {
    string       name;
    logic [21:0] ctl;
    logic [31:0] mdat;
    bit          edge_;
    int          obs;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [31:0] get_obs(input int id);
    case (id)
      O_BUS: return bus;
      O_PC:  return pcq;
      O_IR:  return irq;
      O_MAR: return marq;
      O_R1:  return r1q;
      O_R2:  return r2q;
      O_R3:  return r3q;
      O_ZLO: return zlo;
      default: return zhi;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [21:0] c, input logic [31:0] m,
                     input bit e, input int o, input logic [31:0] x);
    vec_t v;
    v.name = n; v.ctl = c; v.mdat = m; v.edge_ = e; v.obs = o; v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = O_BUS; i <= O_ZHI; i++) check($sformatf("%s_obs%0d", tag, i), get_obs(i), 32'h0);
  endtask

  initial begin
    // Register loads through MDR.
    add("mdr12",     MDRIN|READ,      32'h12, 1, O_NONE, 0);
    add("bus_mdr12", MDROUT,          0,      0, O_BUS,  32'h12);
    add("r2_12",     MDROUT|R2IN,     0,      1, O_R2,   32'h12);
    add("mdr14",     MDRIN|READ,      32'h14, 1, O_NONE, 0);
    add("r3_14",     MDROUT|R3IN,     0,      1, O_R3,   32'h14);
    add("mdr18",     MDRIN|READ,      32'h18, 1, O_NONE, 0);
    add("r1_18",     MDROUT|R1IN,     0,      1, O_R1,   32'h18);
    // Instruction fetch from PC=0.
    add("t0_mar",    PCOUT|MARIN|INCPC|ZIN, 0, 1, O_MAR, 32'h0);
    add("t0_zlo",    ZLOOUT,          0,      0, O_BUS,  32'h1);
    add("t1_pc",     ZLOOUT|PCIN|READ|MDRIN, 32'h28918000, 1, O_PC, 32'h1);
    add("t2_ir",     MDROUT|IRIN,     0,      1, O_IR,   32'h28918000);
    // AND: R1 = R2 & R3 = 0x12 & 0x14.
    add("t3_y",      R2OUT|YIN,       0,      1, O_NONE, 0);
    add("t4_zlo",    R3OUT|ANDOP|ZIN, 0,      1, O_ZLO,  32'h10);
    add("t4_zhi",    0,               0,      0, O_ZHI,  32'h0);
    add("t5_r1",     ZLOOUT|R1IN,     0,      1, O_R1,   32'h10);
    // Bus priority with PC=5, R2=9.
    add("mdr9",      MDRIN|READ,      32'h9,  1, O_NONE, 0);
    add("r2_9",      MDROUT|R2IN,     0,      1, O_R2,   32'h9);
    add("mdr5",      MDRIN|READ,      32'h5,  1, O_NONE, 0);
    add("pc_5",      MDROUT|PCIN,     0,      1, O_PC,   32'h5);
    add("prio_pc",   PCOUT|R2OUT,     0,      0, O_BUS,  32'h5);
    add("prio_mdr_r2", MDROUT|R2OUT|R3OUT, 0, 0, O_BUS,  32'h5);
    add("r2_only",   R2OUT|R3OUT,     0,      0, O_BUS,  32'h9);
    add("no_sel",    0,               0,      0, O_BUS,  32'h0);
    add("hi",        HIOUT|COUT,      0,      0, O_BUS,  32'h0);
    add("lo",        LOOUT,           0,      0, O_BUS,  32'h0);
    add("inport",    INOUT,           0,      0, O_BUS,  32'h0);
    // Default add: Y=9, bus=PC=5.
    add("y9",        R2OUT|YIN,       0,      1, O_NONE, 0);
    add("add_zlo",   PCOUT|ZIN,       0,      1, O_ZLO,  32'he);
    add("zhi_bus",   ZHIOUT,          0,      0, O_BUS,  32'h0);
    // Cout sign extension both ways.
    add("mdr_ir_neg", MDRIN|READ,     32'h00040000, 1, O_NONE, 0);
    add("ir_neg",    MDROUT|IRIN,     0,      1, O_IR,   32'h00040000);
    add("cout_neg",  COUT,            0,      0, O_BUS,  32'hFFFC0000);
    add("mdr_ir_pos", MDRIN|READ,     32'hFFF3FFFF, 1, O_NONE, 0);
    add("ir_pos",    MDROUT|IRIN,     0,      1, O_IR,   32'hFFF3FFFF);
    add("cout_pos",  COUT|INOUT,      0,      0, O_BUS,  32'h0003FFFF);
    // PC wrap.
    add("mdr_ff",    MDRIN|READ,      32'hFFFFFFFF, 1, O_NONE, 0);
    add("pc_ff",     MDROUT|PCIN,     0,      1, O_PC,   32'hFFFFFFFF);
    add("wrap_mar",  PCOUT|MARIN|INCPC|ZIN, 0, 1, O_MAR, 32'hFFFFFFFF);
    add("wrap_pc",   ZLOOUT|PCIN,     0,      1, O_PC,   32'h0);
    add("wrap_zhi",  0,               0,      0, O_ZHI,  32'h0);
    // Drive and load Z in the same cycle: old value drives, new value captured.
    add("zz_1",      ZLOOUT|INCPC|ZIN, 0,     1, O_ZLO,  32'h1);
    add("zz_2",      ZLOOUT|INCPC|ZIN, 0,     1, O_ZLO,  32'h2);

    // Reset state.
    clr = 1'b0; ctl = '0; mdat = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) clr = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      ctl  = vecs[k].ctl;
      mdat = vecs[k].mdat;
      if (vecs[k].edge_) begin
        @(posedge clk);
        #1;
      end else begin
        #1;
      end
      if (vecs[k].obs != O_NONE) check(vecs[k].name, get_obs(vecs[k].obs), vecs[k].exp);
      if (!vecs[k].edge_) ctl = '0;  // nothing loads on the following edge
    end

    // Reset overrides a pending load: MDR=0x55 driven into R1 while clr=0.
    @(negedge clk);
    ctl = MDRIN | READ; mdat = 32'h55;
    @(negedge clk);
    ctl = MDROUT | R1IN; mdat = '0;
    #1 check("pre_rst_bus", bus, 32'h55);
    clr = 1'b0;
    @(posedge clk);
    #1 check_all_zero("rst_ovr");
    @(negedge clk);
    clr = 1'b1; ctl = '0;

    // Reset mid-fetch: abort after T0, then restart fetch from the zero state.
    @(negedge clk);
    ctl = MDRIN | READ; mdat = 32'h7;
    @(negedge clk);
    ctl = MDROUT | PCIN;
    @(negedge clk);
    ctl = PCOUT | MARIN | INCPC | ZIN;
    @(posedge clk);
    #1 check("mid_mar", marq, 32'h7);
    @(negedge clk);
    clr = 1'b0; ctl = ZLOOUT | PCIN;
    @(posedge clk);
    #1 check("mid_pc", pcq, 32'h0);
    check("mid_zlo", zlo, 32'h0);
    @(negedge clk);
    clr = 1'b1; ctl = PCOUT | MARIN | INCPC | ZIN;
    @(posedge clk);
    @(negedge clk);
    ctl = ZLOOUT | PCIN;
    @(posedge clk);
    #1 check("restart_pc", pcq, 32'h1);
    check("restart_mar", marq, 32'h0);
    @(negedge clk);
    ctl = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
